// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus responder.
package cpu_bus_pkg;

  localparam int DATA_SIZE = 32;

  // Wide enough for read latencies up to 7 cycles
  localparam int CNT_W = 3;

  // Active-low byte enables with no lane selected
  localparam logic [3:0] WEB_NONE = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    DM_REQ,
    DM_WAIT,
    IM_REQ,
    IM_WAIT,
    DONE
  } bus_state_t;

endpackage

// File: rtl/bus_lat_counter.sv
// Loadable down-counter timing the SRAM read latency; `last` marks the
// cycle in which the read data is valid on the SRAM output.
module bus_lat_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Load takes priority; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/cpu_bus_responder.sv
// Serializes the CPU's fetch and load/store requests onto one
// single-ported SRAM, stalling the CPU until the cycle's requests are done.
module cpu_bus_responder #(
  parameter int DATA_SIZE = cpu_bus_pkg::DATA_SIZE,
  parameter int ADDR_W    = 14,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 im_read_mem,
  input  logic [31:0]          im_addr,
  input  logic                 dm_read_mem,
  input  logic                 dm_write_mem,
  input  logic [31:0]          dm_addr,
  input  logic [3:0]           dm_web,
  input  logic [DATA_SIZE-1:0] dm_datain,
  output logic [DATA_SIZE-1:0] im_dataout,
  output logic [DATA_SIZE-1:0] dm_dataout,
  output logic                 bus_stall,
  output logic                 mem_cs,
  output logic [3:0]           mem_web,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_SIZE-1:0] mem_din,
  input  logic [DATA_SIZE-1:0] mem_dout
);

  import cpu_bus_pkg::*;

  bus_state_t state;
  bus_state_t state_next;

  logic any_req;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_last;
  logic dm_cap;
  logic im_cap;

  logic [DATA_SIZE-1:0] im_buf;
  logic [DATA_SIZE-1:0] dm_buf;

  // Byte lanes and bits above the SRAM window do not take part in addressing
  logic unused_addr_bits;
  assign unused_addr_bits = ^{im_addr[31:ADDR_W+2], im_addr[1:0],
                              dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  assign any_req = im_read_mem | dm_read_mem | dm_write_mem;

  bus_lat_counter #(
    .WIDTH(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(CNT_W'(RD_LAT)),
    .dec     (cnt_dec),
    .last    (cnt_last)
  );

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: data access first since the MEM-stage request is older
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (dm_read_mem | dm_write_mem) begin
          state_next = DM_REQ;
        end else if (im_read_mem) begin
          state_next = IM_REQ;
        end
      end
      DM_REQ: begin
        if (dm_write_mem) begin
          state_next = im_read_mem ? IM_REQ : DONE;
        end else begin
          state_next = DM_WAIT;
        end
      end
      DM_WAIT: begin
        if (cnt_last) begin
          state_next = im_read_mem ? IM_REQ : DONE;
        end
      end
      IM_REQ:  state_next = IM_WAIT;
      IM_WAIT: begin
        if (cnt_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM strobes, stall and counter controls decoded from the state
  always_comb begin
    bus_stall = 1'b1;
    mem_cs    = 1'b0;
    mem_web   = WEB_NONE;
    mem_addr  = '0;
    mem_din   = '0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    dm_cap    = 1'b0;
    im_cap    = 1'b0;
    unique case (state)
      IDLE: begin
        bus_stall = any_req;
      end
      DM_REQ: begin
        mem_cs   = 1'b1;
        mem_addr = dm_addr[ADDR_W+1:2];
        if (dm_write_mem) begin
          mem_web = dm_web;
          mem_din = dm_datain;
        end else begin
          cnt_load = 1'b1;
        end
      end
      DM_WAIT: begin
        cnt_dec = 1'b1;
        dm_cap  = cnt_last;
      end
      IM_REQ: begin
        mem_cs   = 1'b1;
        mem_addr = im_addr[ADDR_W+1:2];
        cnt_load = 1'b1;
      end
      IM_WAIT: begin
        cnt_dec = 1'b1;
        im_cap  = cnt_last;
      end
      DONE: begin
        bus_stall = 1'b0;
      end
      default: begin
        bus_stall = 1'b0;
      end
    endcase
  end

  // Read buffers hold the last captured word until the next read of that port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_buf <= '0;
      dm_buf <= '0;
    end else begin
      if (im_cap) begin
        im_buf <= mem_dout;
      end
      if (dm_cap) begin
        dm_buf <= mem_dout;
      end
    end
  end

  assign im_dataout = im_buf;
  assign dm_dataout = dm_buf;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomized and directed bench for cpu_bus_responder with an SRAM model
// and a transaction-level reference of memory contents and port results.
module tb_cpu_bus_responder;

  localparam int DW        = 32;
  localparam int ADDR_W    = 14;
  localparam int RD_LAT    = 3;
  localparam int MEM_WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              im_read_mem;
  logic [31:0]       im_addr;
  logic              dm_read_mem;
  logic              dm_write_mem;
  logic [31:0]       dm_addr;
  logic [3:0]        dm_web;
  logic [DW-1:0]     dm_datain;
  logic [DW-1:0]     im_dataout;
  logic [DW-1:0]     dm_dataout;
  logic              bus_stall;
  logic              mem_cs;
  logic [3:0]        mem_web;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW-1:0]     mem_dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram    [0:MEM_WORDS-1];
  logic [DW-1:0] ref_mem [0:MEM_WORDS-1];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  bit            sram_loaded = 1'b0;

  logic [ADDR_W-1:0] cs_log[$];
  logic [DW-1:0]     exp_im;
  logic [DW-1:0]     exp_dm;

  cpu_bus_responder #(
    .DATA_SIZE(DW),
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im_read_mem (im_read_mem),
    .im_addr     (im_addr),
    .dm_read_mem (dm_read_mem),
    .dm_write_mem(dm_write_mem),
    .dm_addr     (dm_addr),
    .dm_web      (dm_web),
    .dm_datain   (dm_datain),
    .im_dataout  (im_dataout),
    .dm_dataout  (dm_dataout),
    .bus_stall   (bus_stall),
    .mem_cs      (mem_cs),
    .mem_web     (mem_web),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 0)  return 32'h0000_0013;
    if (i == 65) return 32'h0000_0000;
    return (i * 32'h9E37_79B1) + 32'h55;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % MEM_WORDS);
  endfunction

  // SRAM model: byte-masked writes, reads valid RD_LAT cycles after the strobe
  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_word(i);
      sram_loaded <= 1'b1;
    end else if (mem_cs) begin
      for (int b = 0; b < 4; b++) begin
        if (!mem_web[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
    end
    rd_pipe[0] <= mem_cs ? sram[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_dout = rd_pipe[RD_LAT-1];

  // Log every SRAM access address, away from the active edge
  always @(negedge clk) begin
    if (mem_cs === 1'b1) cs_log.push_back(mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    im_read_mem  = 1'b0;
    dm_read_mem  = 1'b0;
    dm_write_mem = 1'b0;
    im_addr      = '0;
    dm_addr      = '0;
    dm_web       = 4'hF;
    dm_datain    = '0;
  endtask

  // One CPU cycle's requests; called just after a rising edge with the DUT idle
  task automatic applyStimulus(input logic im_rd, input logic dm_rd,
                               input logic dm_wr, input logic [31:0] im_a,
                               input logic [31:0] dm_a, input logic [3:0] web,
                               input logic [31:0] din);
    int cnt;
    int exp_cnt;
    bit done;
    int dw;
    logic [ADDR_W-1:0] exp_addrs[$];

    cs_log.delete();
    im_read_mem  = im_rd;
    dm_read_mem  = dm_rd;
    dm_write_mem = dm_wr;
    im_addr      = im_a;
    dm_addr      = dm_a;
    dm_web       = web;
    dm_datain    = din;

    exp_cnt = 0;
    dw = word_of(dm_a);
    if (dm_wr) begin
      for (int b = 0; b < 4; b++)
        if (!web[b]) ref_mem[dw][8*b +: 8] = din[8*b +: 8];
      exp_addrs.push_back(ADDR_W'(dw));
      exp_cnt += 1;
    end else if (dm_rd) begin
      exp_dm = ref_mem[dw];
      exp_addrs.push_back(ADDR_W'(dw));
      exp_cnt += 1 + RD_LAT;
    end
    if (im_rd) begin
      exp_im = ref_mem[word_of(im_a)];
      exp_addrs.push_back(ADDR_W'(word_of(im_a)));
      exp_cnt += 1 + RD_LAT;
    end

    @(negedge clk);
    checkOutput("idle_stall", bus_stall, 1'b1);
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus_stall) cnt++;
      else done = 1'b1;
    end
    checkOutput("stall_release", done, 1'b1);
    checkOutput("stall_len", cnt, exp_cnt);
    checkOutput("im_out", im_dataout, exp_im);
    checkOutput("dm_out", dm_dataout, exp_dm);
    checkOutput("done_cs", mem_cs, 1'b0);
    checkOutput("cs_count", cs_log.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size() && i < cs_log.size(); i++)
      checkOutput("cs_addr", cs_log[i], exp_addrs[i]);
    if (dm_wr) checkOutput("sram_word", sram[dw], ref_mem[dw]);

    @(posedge clk);
    #1;
    clearInputs();
  endtask

  initial begin
    logic [2:0]  kind;
    logic [31:0] ia;
    logic [31:0] da;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    exp_im = '0;
    exp_dm = '0;
    rst = 1'b1;
    clearInputs();

    #12;
    $display("[TB] checking reset state");
    checkOutput("rst_stall", bus_stall, 1'b0);
    checkOutput("rst_cs", mem_cs, 1'b0);
    checkOutput("rst_web", mem_web, 4'hF);
    checkOutput("rst_addr", mem_addr, '0);
    checkOutput("rst_din", mem_din, '0);
    checkOutput("rst_im", im_dataout, '0);
    checkOutput("rst_dm", dm_dataout, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] fetch-only from word 0");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0);
    checkOutput("fetch0_im", im_dataout, 32'h0000_0013);

    $display("[TB] store then fetch of the same word");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h0000_0104, 4'b1100,
                  32'hAABB_CCDD);
    checkOutput("store65", sram[65], 32'h0000_CCDD);
    checkOutput("store65_fetch", im_dataout, 32'h0000_CCDD);

    $display("[TB] load plus fetch");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0104, 4'hF, 32'h0);
    checkOutput("load65", dm_dataout, 32'h0000_CCDD);

    $display("[TB] address wrap on fetch");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0001_0008, 32'h0, 4'hF, 32'h0);
    checkOutput("wrap_addr", cs_log[0], 32'd2);

    $display("[TB] idle cycles");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle_stall", bus_stall, 1'b0);
      checkOutput("idle_cs", mem_cs, 1'b0);
      checkOutput("idle_im", im_dataout, exp_im);
      checkOutput("idle_dm", dm_dataout, exp_dm);
    end
    @(posedge clk);
    #1;

    $display("[TB] reset during load wait");
    im_read_mem = 1'b1;
    dm_read_mem = 1'b1;
    im_addr     = 32'h0000_0020;
    dm_addr     = 32'h0000_0030;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_stall", bus_stall, 1'b1);
    checkOutput("midrst_cs", mem_cs, 1'b0);
    checkOutput("midrst_web", mem_web, 4'hF);
    checkOutput("midrst_addr", mem_addr, '0);
    checkOutput("midrst_din", mem_din, '0);
    checkOutput("midrst_im", im_dataout, '0);
    checkOutput("midrst_dm", dm_dataout, '0);
    clearInputs();
    #1;
    checkOutput("midrst_idle", bus_stall, 1'b0);
    exp_im = '0;
    exp_dm = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0030, 4'hF, 32'h0);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      kind = 3'($urandom_range(1, 7));
      ia = ($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      da = ($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ia = ia | ($urandom & 32'hFFFF_0000);
      if ($urandom_range(0, 3) == 0) da = da | ($urandom & 32'hFFFF_0000);
      applyStimulus(kind[0], kind[1], kind[2], ia, da,
                    4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
